puf_resp_gen: RTL and testbench
===============================

PUF_RESP_GEN -- requirements
Module: puf_resp_gen

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10; measurement window length is 2^WIN_LOG2 clk cycles; legal range 4..16.
REQ-002 SHALL have parameter CNT_W, default 16; edge-counter width; SHALL satisfy CNT_W >= WIN_LOG2.
REQ-003 clk  input  1  single block clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to generate one 8-bit response; sampled on clk.
REQ-006 chal_base  input  5  first challenge of the sweep; captured when start is accepted.
REQ-007 osc_a  input  1  selected ring-oscillator output, bank A; asynchronous to clk.
REQ-008 osc_b  input  1  selected ring-oscillator output, bank B; asynchronous to clk.
REQ-009 sel  output  5  challenge driven to both oscillator-bank muxes.
REQ-010 resp  output  8  last completed response word.
REQ-011 resp_valid  output  1  one-cycle pulse when resp is updated.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL synchronise osc_a and osc_b through two flops each, plus a third flop for edge detection; rising edge = sync2 & ~sync3.
REQ-014 SHALL implement states IDLE, SETTLE, MEASURE, COMPARE, DONE.
REQ-015 IDLE: start=1 at a clk edge SHALL capture chal_base into sel, clear the bit index to 0, and go to SETTLE.
REQ-016 SETTLE SHALL last exactly 4 cycles, hold both edge counters at 0, and then go to MEASURE.
REQ-017 MEASURE SHALL last exactly 2^WIN_LOG2 cycles; each detected rising edge SHALL increment the matching counter by 1.
REQ-018 Edges SHALL be counted only while in MEASURE; edges in other states SHALL be discarded.
REQ-019 COMPARE SHALL last 1 cycle and write bit (cnt_a > cnt_b) into response-shadow bit [index]; a tie SHALL yield 0.
REQ-020 After COMPARE, if index < 7: index+1, sel+1 modulo 32 (31 wraps to 0), go to SETTLE; if index == 7: go to DONE.
REQ-021 DONE SHALL last 1 cycle: load resp from the shadow, assert resp_valid, then go to IDLE.
REQ-022 resp SHALL hold its value until the next DONE.
REQ-023 start while busy=1 SHALL be ignored; chal_base changes while busy SHALL have no effect.
REQ-024 start held high SHALL begin a new sweep on the first cycle in IDLE after DONE.
REQ-025 sel SHALL hold its last value in IDLE.
REQ-026 Per-bit time is 5 + 2^WIN_LOG2 cycles; resp_valid SHALL be high in cycle 1 + 8*(5 + 2^WIN_LOG2) after the start-accept edge.
REQ-027 Counters SHALL not wrap within a window, because the synchronised edge rate is at most 1 per 2 cycles.

Reset
REQ-028 While rst_n=0: state=IDLE, sel=0, resp=0, resp_valid=0, busy=0, counters/index/shadow/synchroniser flops=0.
REQ-029 Reset asserted mid-sweep SHALL abort immediately; no resp_valid SHALL be produced for the aborted sweep.

Verification (WIN_LOG2=4, so one window is 16 cycles and valid arrives at cycle 169)
REQ-030 Reset: rst_n=0 at any state -> resp=8'h00, sel=0, busy=0, resp_valid=0 on the next clk.
REQ-031 chal_base=0, osc_a period 2 clk, osc_b period 8 clk, start pulse -> sel steps 0..7, busy=1 for 169 cycles, resp=8'hFF, resp_valid high for exactly 1 cycle at cycle 169.
REQ-032 Same as REQ-031 with the oscillators swapped -> resp=8'h00; both at period 4 (tie) -> resp=8'h00.
REQ-033 chal_base=30; bench drives osc_a period 2 and osc_b period 8 only when sel is odd, else the reverse -> sel sequence 30,31,0,1,2,3,4,5 and resp=8'hAA.
REQ-034 start re-pulsed mid-MEASURE with a different chal_base -> no effect; the sweep completes with the original sel sequence.
REQ-035 rst_n pulsed low during bit 3 of a sweep, then a new start -> no resp_valid from the aborted sweep; the new sweep yields the correct word at cycle 169 after its start.

Source files
------------

// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF response generator: sweeps 8 challenges, compares edge
// counts of two oscillator banks over a fixed window and packs 8 response bits.
module puf_resp_gen #(
    parameter int WIN_LOG2 = 10,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] chal_base,
    input  logic       osc_a,
    input  logic       osc_b,
    output logic [4:0] sel,
    output logic [7:0] resp,
    output logic       resp_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          sel_q, sel_d;
    logic [2:0]          idx_q, idx_d;
    logic [WIN_LOG2-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
    logic [7:0]          shadow_q, shadow_d;
    logic [7:0]          resp_q, resp_d;
    logic                resp_valid_q, resp_valid_d;

    // [0],[1] form the two-flop synchroniser; [2] is the history flop for edge detection.
    logic [2:0] sync_a_q, sync_b_q;
    logic       rise_a, rise_b;

    assign rise_a = sync_a_q[1] & ~sync_a_q[2];
    assign rise_b = sync_b_q[1] & ~sync_b_q[2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[1:0], osc_a};
            sync_b_q <= {sync_b_q[1:0], osc_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            shadow_q     <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            shadow_q     <= shadow_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves a variable unassigned (which would infer a latch).
        state_d      = state_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        shadow_d     = shadow_q;
        resp_d       = resp_q;
        resp_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = chal_base;
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
                timer_d = timer_q + WIN_LOG2'(1);
                if (timer_q == WIN_LOG2'(3)) begin
                    timer_d = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (rise_a) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (rise_b) cnt_b_d = cnt_b_q + CNT_W'(1);
                timer_d = timer_q + WIN_LOG2'(1);
                if (timer_q == '1) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                shadow_d[idx_q] = (cnt_a_q > cnt_b_q);
                if (idx_q == 3'd7) begin
                    // resp and resp_valid become visible during the DONE cycle.
                    resp_d       = shadow_d;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    sel_d   = sel_q + 5'd1;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign resp       = resp_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_puf_resp_gen.sv
// Self-checking bench for puf_resp_gen with WIN_LOG2=4 (16-cycle window, valid at cycle 169).
module tb_puf_resp_gen;

    localparam int WIN_LOG2  = 4;
    localparam int WIN       = 1 << WIN_LOG2;
    localparam int BIT_CYC   = 5 + WIN;
    localparam int VALID_CYC = 1 + 8 * BIT_CYC;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] chal_base;
    logic       osc_a;
    logic       osc_b;
    logic [4:0] sel;
    logic [7:0] resp;
    logic       resp_valid;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Oscillator periods (in clk cycles) selected by the current challenge.
    int per_a [32];
    int per_b [32];
    int ph;

    typedef struct {
        logic [4:0] base;
        int         mode;
        logic [7:0] exp;
        int         repulse;
        string      name;
    } vec_t;

    vec_t vecs [5];

    puf_resp_gen #(
        .WIN_LOG2(WIN_LOG2),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chal_base (chal_base),
        .osc_a     (osc_a),
        .osc_b     (osc_b),
        .sel       (sel),
        .resp      (resp),
        .resp_valid(resp_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int half_per(input int p);
        return (p < 2) ? 1 : p / 2;
    endfunction

    // Square waves derived from a free-running phase, so each is strictly periodic.
    initial begin
        osc_a = 1'b0;
        osc_b = 1'b0;
        ph    = 0;
        forever begin
            @(negedge clk);
            ph++;
            osc_a = ((ph / half_per(per_a[sel])) % 2) == 1;
            osc_b = ((ph / half_per(per_b[sel])) % 2) == 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void set_mode(input int m);
        for (int s = 0; s < 32; s++) begin
            case (m)
                0:       begin per_a[s] = 2; per_b[s] = 8; end
                1:       begin per_a[s] = 8; per_b[s] = 2; end
                2:       begin per_a[s] = 4; per_b[s] = 4; end
                default: begin
                    per_a[s] = (s % 2 == 1) ? 2 : 8;
                    per_b[s] = (s % 2 == 1) ? 8 : 2;
                end
            endcase
        end
    endfunction

    // Reference: a period dividing the window yields exactly WIN/period rising edges.
    function automatic logic [7:0] model_resp(input logic [4:0] base);
        logic [7:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = (int'(base) + i) % 32;
            r[i] = (WIN / per_a[s]) > (WIN / per_b[s]);
        end
        return r;
    endfunction

    task automatic run_sweep(input logic [4:0] base, input logic [7:0] exp,
                             input string name, input int repulse_cyc);
        int busy_cnt, valid_cnt, valid_at, sel_err, idx;
        logic [7:0] resp_at_valid;
        logic [4:0] exp_sel;
        busy_cnt = 0; valid_cnt = 0; valid_at = -1; sel_err = 0;
        resp_at_valid = 'x;
        @(negedge clk);
        start     = 1'b1;
        chal_base = base;
        for (int c = 1; c <= VALID_CYC + 3; c++) begin
            @(negedge clk);
            start = (c == repulse_cyc);
            if (c == repulse_cyc) chal_base = base ^ 5'h11;
            if (busy) busy_cnt++;
            if (resp_valid) begin
                valid_cnt++;
                valid_at      = c;
                resp_at_valid = resp;
            end
            idx     = ((c - 1) / BIT_CYC > 7) ? 7 : (c - 1) / BIT_CYC;
            exp_sel = base + 5'(idx);
            if (sel !== exp_sel) sel_err++;
        end
        check({name, "_sel_seq_errs"}, sel_err, 0);
        check({name, "_busy_cycles"}, busy_cnt, VALID_CYC);
        check({name, "_valid_count"}, valid_cnt, 1);
        check({name, "_valid_cycle"}, valid_at, VALID_CYC);
        check({name, "_resp_at_valid"}, resp_at_valid, exp);
        check({name, "_resp_hold"}, resp, exp);
    endtask

    initial begin
        int vcnt;
        logic [4:0] rb;
        logic [7:0] exp_r;

        rst_n     = 1'b0;
        start     = 1'b0;
        chal_base = '0;
        set_mode(0);

        vecs[0] = '{5'd0,  0, 8'hFF, -1, "a_fast"};
        vecs[1] = '{5'd0,  1, 8'h00, -1, "b_fast"};
        vecs[2] = '{5'd0,  2, 8'h00, -1, "tie"};
        vecs[3] = '{5'd30, 3, 8'hAA, -1, "alt_wrap"};
        vecs[4] = '{5'd9,  3, 8'h55, 30, "repulse"};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_resp", resp, 8'h00);
        check("rst_sel", sel, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", resp_valid, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            set_mode(vecs[i].mode);
            run_sweep(vecs[i].base, vecs[i].exp, vecs[i].name, vecs[i].repulse);
        end

        // start held high restarts on the first IDLE cycle after DONE
        set_mode(0);
        @(negedge clk);
        start     = 1'b1;
        chal_base = 5'd4;
        for (int c = 1; c <= VALID_CYC + 2; c++) begin
            @(negedge clk);
            if (c == VALID_CYC)     check("held_valid", resp_valid, 1'b1);
            if (c == VALID_CYC + 1) check("held_idle_gap", busy, 1'b0);
            if (c == VALID_CYC + 2) check("held_restart", busy, 1'b1);
        end
        start = 1'b0;

        // Reset mid-sweep (during bit 3 of the restarted sweep) aborts with no valid
        repeat (70 - 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_sel", sel, 5'd0);
        check("abort_resp", resp, 8'h00);
        @(negedge clk);
        check("abort_valid", resp_valid, 1'b0);
        check("abort_busy_next", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt  = 0;
        for (int c = 0; c < VALID_CYC + 20; c++) begin
            @(negedge clk);
            if (resp_valid || busy) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        set_mode(3);
        run_sweep(5'd3, model_resp(5'd3), "after_abort", -1);

        // Randomised period tables checked against the edge-count model
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 32; s++) begin
                per_a[s] = 2 << $urandom_range(0, 3);
                per_b[s] = 2 << $urandom_range(0, 3);
            end
            rb    = 5'($urandom_range(0, 31));
            exp_r = model_resp(rb);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(rb, exp_r, $sformatf("rand%0d", r), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
